link_sequencer: RTL and testbench

LINK_SEQUENCER -- requirements
Module: link_sequencer

---
 rtl/link_sequencer_pkg.sv | 23 ++
 rtl/link_sequencer_if.sv | 33 +++
 rtl/link_sequencer_lockout_timer.sv | 38 +++
 rtl/link_sequencer.sv | 157 +++++++++++++++
 tb/tb_link_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_sequencer_pkg.sv
// Shared types and sizing for the link sequencer: FSM state encoding,
// character/length widths and the message-length acceptance rule.
package link_sequencer_pkg;

  localparam int CHAR_W    = 8;
  localparam int MAX_CHARS = 100;
  localparam int LEN_W     = 7;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_LOCKOUT,
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_CHARS));
  endfunction

endpackage

// File: rtl/link_sequencer_if.sv
// Bundle of the sequencer's handshake, data and status signals; the master
// side drives codes, commands and characters, the slave side is the sequencer.
interface link_sequencer_if;
  import link_sequencer_pkg::*;

  logic [3:0]        password;
  logic              pw_valid;
  logic              start;
  logic [LEN_W-1:0]  msg_len;
  logic [CHAR_W-1:0] char_in;
  logic              abort;
  logic              relock;

  logic              char_req;
  logic              serial_out;
  logic              serial_valid;
  logic [LEN_W-1:0]  char_index;
  logic              busy;
  logic              done;
  logic              err;
  logic              locked;

  modport master (
    output password, pw_valid, start, msg_len, char_in, abort, relock,
    input  char_req, serial_out, serial_valid, char_index, busy, done, err, locked
  );

  modport slave (
    input  password, pw_valid, start, msg_len, char_in, abort, relock,
    output char_req, serial_out, serial_valid, char_index, busy, done, err, locked
  );

endinterface

// File: rtl/link_sequencer_lockout_timer.sv
// Lockout down-counter: loads the full duration, counts down while enabled,
// and flags the final counting cycle so the FSM can leave lockout on time.
module lockout_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load_i,
  input  logic count_i,
  output logic zero_o,
  output logic expire_o
);

  localparam int W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(CYCLES);
    else if (count_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o   = (cnt_q == '0);
  // Counting from CYCLES down to 1 spans exactly CYCLES clocks.
  assign expire_o = count_i && (cnt_q <= W'(1));

endmodule

// File: rtl/link_sequencer.sv
// Password-gated message sequencer: fetches characters from an external
// encrypter one at a time and serializes each LSB first on serial_out.
module link_sequencer
  import link_sequencer_pkg::*;
#(
  parameter logic [3:0] PASSWORD       = 4'b0101,
  parameter int         MAX_TRIES      = 3,
  parameter int         LOCKOUT_CYCLES = 1024
) (
  input logic             clock,
  input logic             reset_n,
  link_sequencer_if.slave bus
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  state_t              state_q, state_d;
  logic [TRIES_W-1:0]  tries_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [LEN_W-1:0]    idx_next;
  logic [CHAR_W-1:0]   sr_q;
  logic [2:0]          bit_q;
  logic                err_q;

  logic pw_hit, pw_miss, last_try, last_bit, accept;
  logic tmr_load, tmr_zero, tmr_expire;

  logic char_req, serial_out, serial_valid, busy, done, locked;

  assign pw_hit   = bus.pw_valid && (bus.password == PASSWORD);
  assign pw_miss  = bus.pw_valid && (bus.password != PASSWORD);
  assign last_try = (tries_q == TRIES_W'(MAX_TRIES - 1));
  assign last_bit = (bit_q == 3'd7);
  assign idx_next = idx_q + LEN_W'(1);
  assign accept   = (state_q == ST_IDLE) && (state_d == ST_FETCH);
  assign tmr_load = (state_q == ST_LOCKED) && (state_d == ST_LOCKOUT);

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (tmr_load),
    .count_i  (state_q == ST_LOCKOUT),
    .zero_o   (tmr_zero),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_LOCKED;
    else
      state_q <= state_d;
  end

  // Relock wins over everything except an active lockout, which must run out.
  always_comb begin
    state_d = state_q;
    if (bus.relock && (state_q != ST_LOCKOUT)) begin
      state_d = ST_LOCKED;
    end else begin
      case (state_q)
        ST_LOCKED: begin
          if (pw_hit)
            state_d = ST_IDLE;
          else if (pw_miss && last_try)
            state_d = ST_LOCKOUT;
        end
        ST_LOCKOUT: begin
          if (tmr_expire || tmr_zero)
            state_d = ST_LOCKED;
        end
        ST_IDLE: begin
          if (bus.start && len_ok(bus.msg_len))
            state_d = ST_FETCH;
        end
        ST_FETCH: state_d = bus.abort ? ST_IDLE : ST_LOAD;
        ST_LOAD:  state_d = bus.abort ? ST_IDLE : ST_SHIFT;
        ST_SHIFT: begin
          if (bus.abort)
            state_d = ST_IDLE;
          else if (last_bit)
            state_d = (idx_next == len_q) ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_LOCKED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tries_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && bus.start && !len_ok(bus.msg_len) && !bus.relock;

      if (bus.relock || (state_d != ST_LOCKED))
        tries_q <= '0;
      else if ((state_q == ST_LOCKED) && pw_miss)
        tries_q <= tries_q + TRIES_W'(1);

      if (accept)
        len_q <= bus.msg_len;

      if ((state_d == ST_LOCKED) || accept)
        idx_q <= '0;
      else if ((state_q == ST_SHIFT) && last_bit)
        idx_q <= idx_next;

      if (state_q == ST_LOAD) begin
        sr_q  <= bus.char_in;
        bit_q <= '0;
      end else if (state_q == ST_SHIFT) begin
        sr_q  <= {1'b0, sr_q[CHAR_W-1:1]};
        bit_q <= bit_q + 3'd1;
      end
    end
  end

  always_comb begin
    char_req     = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    locked       = 1'b0;
    case (state_q)
      ST_LOCKED, ST_LOCKOUT: locked = 1'b1;
      ST_FETCH: begin
        char_req = 1'b1;
        busy     = 1'b1;
      end
      ST_LOAD:  busy = 1'b1;
      ST_SHIFT: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = sr_q[0];
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.char_req     = char_req;
  assign bus.serial_out   = serial_out;
  assign bus.serial_valid = serial_valid;
  assign bus.char_index   = idx_q;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err_q;
  assign bus.locked       = locked;

endmodule

// File: tb/tb_link_sequencer.sv
// Bench for link_sequencer: command table, lockout timing, abort/relock/reset
// corner cases and random messages compared against a transaction-level model.
module tb_link_sequencer;
  import link_sequencer_pkg::*;

  localparam logic [3:0] PW       = 4'b0101;
  localparam int         LOCK_CYC = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  link_sequencer_if bus();

  link_sequencer #(.PASSWORD(PW), .MAX_TRIES(3), .LOCKOUT_CYCLES(LOCK_CYC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] pw;
    bit         pwv;
    bit         st;
    logic [6:0] len;
    bit         rl;
    bit         ab;
    bit         e_locked;
    bit         e_err;
    bit         e_busy;
    bit         e_req;
  } vec_t;

  typedef struct {
    int cyc;
    bit b;
  } ev_t;

  vec_t        tbl[$];
  byte unsigned msg_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus.char_req, bus.serial_out, bus.serial_valid, bus.char_index,
            bus.busy, bus.done, bus.err, bus.locked};
  endfunction

  function automatic vec_t mk(logic [3:0] pw, bit pwv, bit st, logic [6:0] len, bit rl, bit ab,
                              bit el, bit ee, bit eb, bit er);
    vec_t v;
    v.pw = pw; v.pwv = pwv; v.st = st; v.len = len; v.rl = rl; v.ab = ab;
    v.e_locked = el; v.e_err = ee; v.e_busy = eb; v.e_req = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.password = 4'h0;
    bus.pw_valid = 1'b0;
    bus.start    = 1'b0;
    bus.msg_len  = 7'd0;
    bus.abort    = 1'b0;
    bus.relock   = 1'b0;
  endtask

  // Expected stream: bit j of character k appears at cycle 10k+3+j after the
  // accepted start; char_req for character k at 10k+1; done at 10*len+1.
  task automatic run_msg(input int abort_at, input bit noise, input string tag);
    int   len = msg_q.size();
    bit   ab  = (abort_at > 0);
    ev_t  exp_q[$];
    ev_t  got_q[$];
    int   req_cnt = 0, exp_req = 0, done_cnt = 0, done_cyc = -1;
    int   err_cnt = 0, so_bad = 0, busy_bad = 0, idx_bad = 0, bit_bad = 0, nxt = 0;
    int   limit;
    bit   prev_req = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (!ab || (10*k + 1 <= abort_at)) exp_req++;
      for (int j = 0; j < 8; j++) begin
        ev_t e;
        e.cyc = 10*k + 3 + j;
        e.b   = msg_q[k][j];
        if (!ab || (e.cyc <= abort_at)) exp_q.push_back(e);
      end
    end
    limit = ab ? abort_at + 3 : 10*len + 3;
    bus.start   = 1'b1;
    bus.msg_len = 7'(len);
    for (int cyc = 1; cyc <= limit; cyc++) begin
      tick();
      if (bus.char_req) req_cnt++;
      if (bus.serial_valid) begin
        ev_t e;
        e.cyc = cyc;
        e.b   = bus.serial_out;
        got_q.push_back(e);
        if (int'(bus.char_index) != (cyc - 3) / 10) idx_bad++;
      end else if (bus.serial_out !== 1'b0) begin
        so_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.err) err_cnt++;
      if (bus.busy !== ((cyc <= 10*len) && (!ab || cyc <= abort_at))) busy_bad++;
      bus.char_in = (prev_req && nxt < len) ? msg_q[nxt] : 8'($urandom);
      if (prev_req) nxt++;
      prev_req    = bus.char_req;
      bus.abort   = (cyc == abort_at);
      bus.start   = noise && (cyc < (ab ? abort_at : 10*len)) && ($urandom_range(0, 3) == 0);
      bus.msg_len = 7'($urandom);
    end
    idle_inputs();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if ((got_q[i].cyc != exp_q[i].cyc) || (got_q[i].b != exp_q[i].b)) bit_bad++;
    check({tag, "_nbits"}, got_q.size(), exp_q.size());
    check({tag, "_bad_bits"}, bit_bad, 0);
    check({tag, "_char_req_count"}, req_cnt, exp_req);
    check({tag, "_done_count"}, done_cnt, ab ? 0 : 1);
    if (!ab) check({tag, "_done_cycle"}, done_cyc, 10*len + 1);
    check({tag, "_err_pulses"}, err_cnt, 0);
    check({tag, "_serial_out_idle"}, so_bad, 0);
    check({tag, "_busy_cycles"}, busy_bad, 0);
    check({tag, "_char_index"}, idx_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    idle_inputs();
    bus.char_in = 8'h00;

    // Reset: only locked high while reset_n is low.
    @(posedge clock);
    #1;
    check("reset_outs", outs(), 14'h0001);
    #2 reset_n = 1'b1;
    tick();
    check("post_reset_outs", outs(), 14'h0001);

    tbl.push_back(mk(4'h3, 1, 0, 7'd0,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(4'hA, 1, 0, 7'd0,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(PW,   1, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd101, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd127, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'h3, 1, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd5,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(PW,   1, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd100, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(PW,   1, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 7'd1,   0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 7'd0,   0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      bus.password = tbl[i].pw;
      bus.pw_valid = tbl[i].pwv;
      bus.start    = tbl[i].st;
      bus.msg_len  = tbl[i].len;
      bus.relock   = tbl[i].rl;
      bus.abort    = tbl[i].ab;
      tick();
      idle_inputs();
      check($sformatf("tbl%0d_locked", i), bus.locked, tbl[i].e_locked);
      check($sformatf("tbl%0d_err", i), bus.err, tbl[i].e_err);
      check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_char_req", i), bus.char_req, tbl[i].e_req);
    end

    // Lockout: correct codes and relock are ignored for exactly LOCK_CYC cycles.
    bus.relock = 1'b1;
    tick();
    idle_inputs();
    check("relock_locked", bus.locked, 1'b1);
    for (int n = 0; n < 3; n++) begin
      bus.password = 4'hF;
      bus.pw_valid = 1'b1;
      tick();
      idle_inputs();
    end
    for (int t = 1; t <= LOCK_CYC + 1; t++) begin
      check($sformatf("lockout_hold_t%0d", t), bus.locked, 1'b1);
      bus.password = PW;
      bus.pw_valid = (t == 5) || (t == 10) || (t == LOCK_CYC) || (t == LOCK_CYC + 1);
      bus.relock   = (t == 8);
      tick();
    end
    idle_inputs();
    check("lockout_release_unlock", bus.locked, 1'b0);

    msg_q = '{8'hA5, 8'h3C};
    run_msg(0, 0, "two_chars");
    msg_q = '{8'h5A, 8'hC3};
    run_msg(7, 0, "abort_bit4");
    run_msg(0, 0, "after_abort");

    for (int it = 0; it < 10; it++) begin
      int len = (it == 0) ? 100 : (it == 1) ? 1 : $urandom_range(1, 6);
      int ab  = 0;
      msg_q.delete();
      for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
      if (it > 1 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, 10*len);
      run_msg(ab, 1'b1, $sformatf("rnd%0d", it));
    end

    // Relock together with abort in the middle of character 1.
    bus.start   = 1'b1;
    bus.msg_len = 7'd3;
    bus.char_in = 8'hFF;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      idle_inputs();
    end
    check("mid_shift_valid", bus.serial_valid, 1'b1);
    bus.relock = 1'b1;
    bus.abort  = 1'b1;
    tick();
    idle_inputs();
    check("relock_abort_outs", outs(), 14'h0001);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) dcnt++;
    end
    check("relock_abort_no_done", dcnt, 0);
    check("relock_abort_locked", bus.locked, 1'b1);

    // Reset in the middle of a transfer.
    bus.password = PW;
    bus.pw_valid = 1'b1;
    tick();
    idle_inputs();
    check("reunlock", bus.locked, 1'b0);
    bus.start   = 1'b1;
    bus.msg_len = 7'd2;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      idle_inputs();
    end
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_outs", outs(), 14'h0001);
    tick();
    check("reset_held_outs", outs(), 14'h0001);
    #2 reset_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done || bus.busy) dcnt++;
    end
    check("reset_no_resume", dcnt, 0);
    check("reset_locked", bus.locked, 1'b1);

    bus.password = PW;
    bus.pw_valid = 1'b1;
    tick();
    idle_inputs();
    msg_q = '{8'h81};
    run_msg(0, 1'b1, "recover");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
